// File: rtl/pc_ras_if.sv
// pc_ras_if: decode-side control strobes and fetch-side PC/RAS status.
// MISALIGN exists only when PC_ALIGN_CHECK_EN is defined.
interface pc_ras_if #(
    parameter int WIDTH = 32
);
    logic             ENABLE;
    logic [2:0]       MODE;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] PC_OUT;
    logic             RAS_FULL;
    logic             RAS_EMPTY;
    logic             RAS_ERR;
`ifdef PC_ALIGN_CHECK_EN
    logic             MISALIGN;

    modport master (
        output ENABLE, MODE, D,
        input  PC_OUT, RAS_FULL, RAS_EMPTY, RAS_ERR, MISALIGN
    );

    modport slave (
        input  ENABLE, MODE, D,
        output PC_OUT, RAS_FULL, RAS_EMPTY, RAS_ERR, MISALIGN
    );
`else
    modport master (
        output ENABLE, MODE, D,
        input  PC_OUT, RAS_FULL, RAS_EMPTY, RAS_ERR
    );

    modport slave (
        input  ENABLE, MODE, D,
        output PC_OUT, RAS_FULL, RAS_EMPTY, RAS_ERR
    );
`endif
endinterface

// File: rtl/pc_ras.sv
// pc_ras: fetch-stage program counter with relative branch and return-address stack.
// Optional target alignment check enabled by defining PC_ALIGN_CHECK_EN.
module pc_ras #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_VEC = 32'h1A000000,
    parameter int          STEP      = 4,
    parameter int          RAS_DEPTH = 4
) (
    input logic      CLK,
    input logic      RES,
    pc_ras_if.slave  bus
);

    localparam int PW = $clog2(RAS_DEPTH + 1);
    localparam int IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    localparam logic [WIDTH-1:0] RST_PC  = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [PW-1:0]    DEPTH_P = PW'(RAS_DEPTH);

    localparam logic [2:0] M_INC  = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_REL  = 3'b010;
    localparam logic [2:0] M_CALL = 3'b011;
    localparam logic [2:0] M_RET  = 3'b100;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_nx;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] top;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_dec;
    logic [WIDTH-1:0] stack [RAS_DEPTH];
    logic             full;
    logic             empty;
    logic             err;
    logic             push;
    logic             pop;
    logic             err_set;
    logic             hold;

    assign pc_inc  = pc + STEP_W;
    assign ptr_dec = ptr - PW'(1);
    assign top     = stack[IW'(ptr_dec)];
    assign full    = (ptr == DEPTH_P);
    assign empty   = (ptr == '0);

    assign bus.PC_OUT    = pc;
    assign bus.RAS_FULL  = full;
    assign bus.RAS_EMPTY = empty;
    assign bus.RAS_ERR   = err;

    // Decode MODE into the next PC and the stack/flag side effects.
    always_comb begin
        pc_nx   = pc;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        case (bus.MODE)
            M_INC: begin
                pc_nx = pc_inc;
            end
            M_LOAD: begin
                pc_nx = bus.D;
            end
            M_REL: begin
                pc_nx = pc + bus.D;
            end
            M_CALL: begin
                pc_nx = bus.D;
                if (full) begin
                    err_set = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
            M_RET: begin
                if (empty) begin
                    pc_nx   = pc_inc;
                    err_set = 1'b1;
                end else begin
                    pc_nx = top;
                    pop   = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [WIDTH-1:0] AMASK =
        (STEP > 1) ? WIDTH'((1 << $clog2(STEP)) - 1) : '0;

    logic chk;
    logic mis;

    // Only jump targets and popped return addresses are alignment-checked.
    assign chk = (bus.MODE == M_LOAD) || (bus.MODE == M_REL) ||
                 (bus.MODE == M_CALL) || ((bus.MODE == M_RET) && !empty);
    assign hold = chk && ((pc_nx & AMASK) != '0);

    assign bus.MISALIGN = mis;

    // One-cycle pulse reporting a rejected misaligned target.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            mis <= 1'b0;
        end else begin
            mis <= bus.ENABLE && hold;
        end
    end
`else
    assign hold = 1'b0;
`endif

    // PC, stack pointer and sticky error register.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            pc  <= RST_PC;
            ptr <= '0;
            err <= 1'b0;
        end else if (bus.ENABLE && !hold) begin
            pc <= pc_nx;
            if (push) begin
                ptr <= ptr + PW'(1);
            end else if (pop) begin
                ptr <= ptr_dec;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Stack storage; contents need no reset, only the pointer does.
    always_ff @(posedge CLK) begin
        if (!RES && bus.ENABLE && !hold && push) begin
            stack[IW'(ptr)] <= pc_inc;
        end
    end

endmodule

// File: doc/pc_ras.md
Name: pc_ras

Overview:
- Parametrised successor to the core's program counter.
- Adds a configurable width, reset vector and increment step.
- Adds PC-relative branches and a hardware return-address stack (RAS) for call/return.
- Sits in the fetch stage. PC_OUT drives the instruction-memory address. The decode/branch unit drives MODE, D and ENABLE.

Parameters:
- WIDTH, 32: PC and D width in bits.
- RESET_VEC, 32'h1A000000: PC value after reset (truncated to WIDTH).
- STEP, 4: increment applied in INC mode and for the return address.
- RAS_DEPTH, 4: number of return-address entries (>=1).

Ports:
- CLK, input, 1: rising-edge clock.
- RES, input, 1: asynchronous, active-high reset.
- ENABLE, input, 1: update strobe; 0 freezes all state.
- MODE, input, 3: operation select (see Behaviour).
- D, input, WIDTH: absolute target (LOAD/CALL) or two's-complement offset (REL).
- PC_OUT, output, WIDTH: current program counter (registered).
- RAS_FULL, output, 1: stack holds RAS_DEPTH entries.
- RAS_EMPTY, output, 1: stack holds 0 entries.
- RAS_ERR, output, 1: sticky flag, set on any overflow or underflow.

Behaviour:
- Reset:
  - RES high forces, immediately and independent of CLK: PC_OUT=RESET_VEC, stack pointer=0, RAS_EMPTY=1, RAS_FULL=0, RAS_ERR=0.
  - Stack entry contents are don't-care.
  - RES asserted mid-operation aborts any pending update; the first edge after deassertion executes normally.
- Update timing: all state changes on the rising CLK edge when ENABLE=1 and RES=0. Latency is one cycle: the new PC is visible after that edge.
- ENABLE=0: PC, stack and flags hold regardless of MODE and D.
- MODE encoding:
  - 000 INC: PC <= PC + STEP.
  - 001 LOAD: PC <= D.
  - 010 REL: PC <= PC + D, with D treated as signed.
  - 011 CALL: push (PC + STEP), then PC <= D.
  - 100 RET: pop the top entry, PC <= popped value.
  - 101..111 reserved: PC and stack hold, no flag change.
- Arithmetic: all additions are modulo 2^WIDTH, so wrap-around is silent. Example for WIDTH=32: PC=FFFFFFFC with INC gives 00000000.
- Stack:
  - LIFO with pointer range 0..RAS_DEPTH.
  - RAS_FULL is (ptr==RAS_DEPTH); RAS_EMPTY is (ptr==0). Both are combinational from the registered pointer.
- CALL when full: the jump is still performed, the push is suppressed (stack unchanged), and RAS_ERR is set.
- RET when empty: PC <= PC + STEP, pointer stays 0, and RAS_ERR is set.
- RAS_ERR is cleared only by RES.
- Only one operation executes per edge; MODE fully decides it. CALL immediately followed by RET returns to the call site + STEP.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- With the macro defined:
  - An extra output port MISALIGN (1 bit, reset 0) is present.
  - Alignment rule: a target is misaligned if its low log2(STEP) bits are not zero. This applies to LOAD, REL and CALL targets, and to RET popped values.
  - On an enabled edge with a misaligned target: PC and stack hold, RAS_ERR is unaffected, and MISALIGN goes high for exactly one cycle (registered pulse).
  - For STEP=1 the check is disabled; MISALIGN stays 0.
- Without the macro: no MISALIGN port, targets are used unmodified.

Test Plan:
- Reset and increment: assert RES, release, check PC_OUT=1A000000. ENABLE=1, MODE=000, 3 edges -> 1A00000C. ENABLE=0, 2 edges -> still 1A00000C.
- Load and relative branch: MODE=001, D=00001000 -> 00001000. MODE=010, D=FFFFFFF0 -> 00000FF0. MODE=010, D=00000020 -> 00001010.
- Nested call/return: PC=00000100. CALL D=00002000, then CALL D=00003000; check RAS_EMPTY=0. RET -> 00002004, RET -> 00000104, RAS_EMPTY=1, RAS_ERR=0.
- Overflow and underflow (RAS_DEPTH=4):
  - 5 CALLs: the 5th jumps, RAS_FULL=1, RAS_ERR=1.
  - 4 RETs return the first four return addresses in reverse order.
  - A 5th RET gives PC = PC + 4.
  - RAS_ERR stays 1 until RES.
- Async reset mid-operation: assert RES between edges after 2 CALLs; PC_OUT=1A000000 before the next edge, RAS_EMPTY=1, RAS_ERR=0.
- Wrap and alignment: LOAD FFFFFFFC then INC -> 00000000. With PC_ALIGN_CHECK_EN, LOAD D=00000006 -> PC holds, MISALIGN high for one cycle only.
